// File: rtl/sdram_prefetch_ctrl_if.sv
// Prefetch controller bus bundle: QSPI request side, SDRAM read port and line-buffer write port.
// master is the controller's view; slave is the surrounding system's view.
interface sdram_prefetch_ctrl_if;
  logic        qspi_rd_req;
  logic [23:0] qspi_rd_addr;
  logic        qspi_rd_busy;
  logic        sdr_rd_req;
  logic [23:0] sdr_rd_addr;
  logic        sdr_rd_ack;
  logic        sdr_rd_valid;
  logic [15:0] sdr_rd_data;
  logic        ram_wen;
  logic [2:0]  ram_waddr;
  logic [15:0] ram_wdata;
  logic        prefetch_err;

  modport master (
    input  qspi_rd_req, qspi_rd_addr, sdr_rd_ack, sdr_rd_valid, sdr_rd_data,
    output qspi_rd_busy, sdr_rd_req, sdr_rd_addr, ram_wen, ram_waddr, ram_wdata, prefetch_err
  );

  modport slave (
    output qspi_rd_req, qspi_rd_addr, sdr_rd_ack, sdr_rd_valid, sdr_rd_data,
    input  qspi_rd_busy, sdr_rd_req, sdr_rd_addr, ram_wen, ram_waddr, ram_wdata, prefetch_err
  );
endinterface

// File: rtl/sdram_prefetch_ctrl.sv
// Fetches one 8x16-bit line from SDRAM per QSPI request; 3-cycle request sync, all outputs registered.
// Holds sdr_rd_req until acked, one pending request queued while busy, idle-wait timeout aborts.
module sdram_prefetch_ctrl #(
  parameter int TIMEOUT_CYC = 1023
) (
  input logic                   sd_clk,
  input logic                   rst,
  sdram_prefetch_ctrl_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, sync3_q;
  logic [23:0]   addr_q, addr_d;
  logic [23:0]   pend_addr_q, pend_addr_d;
  logic          pend_q, pend_d;
  logic          busy_q, busy_d;
  logic          req_q, req_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          wen_q, wen_d;
  logic [2:0]    waddr_q, waddr_d;
  logic [15:0]   wdata_q, wdata_d;

  logic          req_evt;
  logic [23:0]   cap_addr;
  logic          unused_addr_lo;

  assign req_evt        = sync2_q & ~sync3_q;
  assign cap_addr       = {bus.qspi_rd_addr[23:4], 4'h0};
  assign unused_addr_lo = ^bus.qspi_rd_addr[3:0];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_addr_d = pend_addr_q;
    pend_d      = pend_q;
    busy_d      = busy_q;
    req_d       = req_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    err_d       = 1'b0;
    wen_d       = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    // Requests landing mid-burst (DONE included) queue behind it; newest address wins.
    if (req_evt && state_q != IDLE) begin
      pend_d      = 1'b1;
      pend_addr_d = cap_addr;
    end

    case (state_q)
      IDLE: begin
        if (req_evt || pend_q) begin
          state_d = REQ;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          addr_d  = req_evt ? cap_addr : pend_addr_q;
          pend_d  = 1'b0;
          tmo_d   = '0;
        end
      end
      REQ: begin
        if (bus.sdr_rd_ack) begin
          state_d = DATA;
          req_d   = 1'b0;
          idx_d   = 3'd0;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          pend_d  = 1'b0;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DATA: begin
        if (bus.sdr_rd_valid) begin
          wen_d   = 1'b1;
          waddr_d = idx_q;
          wdata_d = bus.sdr_rd_data;
          idx_d   = idx_q + 3'd1;
          tmo_d   = '0;
          if (idx_q == 3'd7) state_d = DONE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          pend_d  = 1'b0;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = pend_d;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      addr_q      <= '0;
      pend_addr_q <= '0;
      pend_q      <= 1'b0;
      busy_q      <= 1'b0;
      req_q       <= 1'b0;
      idx_q       <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= bus.qspi_rd_req;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      addr_q      <= addr_d;
      pend_addr_q <= pend_addr_d;
      pend_q      <= pend_d;
      busy_q      <= busy_d;
      req_q       <= req_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.qspi_rd_busy = busy_q;
  assign bus.sdr_rd_req   = req_q;
  assign bus.sdr_rd_addr  = addr_q;
  assign bus.ram_wen      = wen_q;
  assign bus.ram_waddr    = waddr_q;
  assign bus.ram_wdata    = wdata_q;
  assign bus.prefetch_err = err_q;

endmodule

// File: tb/tb_sdram_prefetch_ctrl.sv
// Directed bench for sdram_prefetch_ctrl: single, gapped, back-to-back, timeout, reset and stray-data cases.
module tb_sdram_prefetch_ctrl;
  localparam int TMO = 40;

  logic sd_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   err_cnt = 0;
  int   n;
  int   gap_tbl[8] = '{0, 1, 2, 3, 4, 5, 0, 3};
  logic [18:0] wr_q[$];

  sdram_prefetch_ctrl_if bus();

  sdram_prefetch_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .sd_clk (sd_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sd_clk = ~sd_clk;

  always @(negedge sd_clk) begin
    if (bus.ram_wen === 1'b1) wr_q.push_back({bus.ram_waddr, bus.ram_wdata});
    if (bus.prefetch_err === 1'b1) err_cnt++;
  end

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.qspi_rd_busy), 32'd0);
    chk({tag, "_req"},   32'(bus.sdr_rd_req),   32'd0);
    chk({tag, "_addr"},  32'(bus.sdr_rd_addr),  32'd0);
    chk({tag, "_wen"},   32'(bus.ram_wen),      32'd0);
    chk({tag, "_waddr"}, 32'(bus.ram_waddr),    32'd0);
    chk({tag, "_wdata"}, 32'(bus.ram_wdata),    32'd0);
    chk({tag, "_err"},   32'(bus.prefetch_err), 32'd0);
  endtask

  // Address settles two cycles ahead, request held two cycles; returns one cycle after capture edge.
  task automatic issue_req(input logic [23:0] a, input logic exp_busy);
    bus.qspi_rd_addr = a;
    tick();
    tick();
    bus.qspi_rd_req = 1'b1;
    tick();
    tick();
    chk("busy_before_evt", 32'(bus.qspi_rd_busy), 32'(exp_busy));
    bus.qspi_rd_req = 1'b0;
    tick();
  endtask

  task automatic send_beats(input int cnt, input logic [15:0] base, input bit gapped);
    for (int i = 0; i < cnt; i++) begin
      repeat (gapped ? gap_tbl[i] : 0) tick();
      bus.sdr_rd_valid = 1'b1;
      bus.sdr_rd_data  = base + 16'(i);
      tick();
      bus.sdr_rd_valid = 1'b0;
    end
  endtask

  task automatic chk_log(input string tag, input int cnt, input logic [15:0] base);
    logic [18:0] e;
    chk({tag, "_wr_count"}, 32'(wr_q.size()), 32'(cnt));
    for (int i = 0; i < cnt; i++) begin
      e = {i[2:0], base + 16'(i)};
      if (i < wr_q.size()) chk({tag, "_wr_entry"}, 32'(wr_q[i]), 32'(e));
    end
    wr_q.delete();
  endtask

  task automatic ack_now();
    bus.sdr_rd_ack = 1'b1;
    tick();
    bus.sdr_rd_ack = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.qspi_rd_req  = 1'b0;
    bus.qspi_rd_addr = '0;
    bus.sdr_rd_ack   = 1'b0;
    bus.sdr_rd_valid = 1'b0;
    bus.sdr_rd_data  = '0;
    #1;
    chk_outputs_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single prefetch, ack three cycles after REQ entry.
    issue_req(24'h01234A, 1'b0);
    chk("t1_req",  32'(bus.sdr_rd_req),   32'd1);
    chk("t1_addr", 32'(bus.sdr_rd_addr),  32'h012340);
    chk("t1_busy", 32'(bus.qspi_rd_busy), 32'd1);
    tick();
    tick();
    chk("t1_req_held", 32'(bus.sdr_rd_req), 32'd1);
    ack_now();
    chk("t1_req_drop", 32'(bus.sdr_rd_req),   32'd0);
    chk("t1_busy_dat", 32'(bus.qspi_rd_busy), 32'd1);
    send_beats(8, 16'h1000, 1'b0);
    chk("t1_done_busy",  32'(bus.qspi_rd_busy), 32'd1);
    chk("t1_last_waddr", 32'(bus.ram_waddr),    32'd7);
    chk("t1_last_wdata", 32'(bus.ram_wdata),    32'h1007);
    tick();
    chk("t1_busy_fall", 32'(bus.qspi_rd_busy), 32'd0);
    chk_log("t1", 8, 16'h1000);

    // Gapped beats.
    issue_req(24'h00ABCD, 1'b0);
    chk("t2_addr", 32'(bus.sdr_rd_addr), 32'h00ABC0);
    ack_now();
    send_beats(8, 16'h2200, 1'b1);
    tick();
    tick();
    chk_log("t2", 8, 16'h2200);
    chk("t2_no_err", 32'(err_cnt), 32'd0);
    chk("t2_idle_busy", 32'(bus.qspi_rd_busy), 32'd0);

    // Two further requests during burst one; only the last one is fetched next.
    issue_req(24'h000030, 1'b0);
    ack_now();
    issue_req(24'h000050, 1'b1);
    issue_req(24'h000070, 1'b1);
    chk("t3_active_addr", 32'(bus.sdr_rd_addr), 32'h000030);
    send_beats(8, 16'h3000, 1'b0);
    chk("t3_done_busy", 32'(bus.qspi_rd_busy), 32'd1);
    tick();
    chk("t3_idle_busy", 32'(bus.qspi_rd_busy), 32'd1);
    chk("t3_idle_req",  32'(bus.sdr_rd_req),   32'd0);
    tick();
    chk("t3_req2",  32'(bus.sdr_rd_req),  32'd1);
    chk("t3_addr2", 32'(bus.sdr_rd_addr), 32'h000070);
    chk_log("t3a", 8, 16'h3000);
    ack_now();
    send_beats(8, 16'h7000, 1'b0);
    tick();
    chk("t3_busy_fall", 32'(bus.qspi_rd_busy), 32'd0);
    tick();
    tick();
    chk("t3_no_third", 32'(bus.sdr_rd_req), 32'd0);
    chk_log("t3b", 8, 16'h7000);

    // Timeout with no ack.
    issue_req(24'h00F00F, 1'b0);
    chk("t4_req", 32'(bus.sdr_rd_req), 32'd1);
    n = 0;
    while (bus.prefetch_err !== 1'b1 && n < TMO + 20) begin
      tick();
      n++;
    end
    chk("t4_err_delay", 32'(n),                TMO);
    chk("t4_req_low",   32'(bus.sdr_rd_req),   32'd0);
    chk("t4_busy_low",  32'(bus.qspi_rd_busy), 32'd0);
    tick();
    chk("t4_err_pulse", 32'(bus.prefetch_err), 32'd0);
    chk("t4_err_count", 32'(err_cnt),          32'd1);
    tick();
    chk("t4_stay_idle", 32'(bus.sdr_rd_req),   32'd0);

    // Reset mid-DATA after beat 3, beats 4..7 still driven.
    issue_req(24'h000100, 1'b0);
    ack_now();
    send_beats(4, 16'h2000, 1'b0);
    chk("t5_wen_b3",   32'(bus.ram_wen),   32'd1);
    chk("t5_waddr_b3", 32'(bus.ram_waddr), 32'd3);
    bus.sdr_rd_valid = 1'b1;
    bus.sdr_rd_data  = 16'h2004;
    #5;
    chk_log("t5pre", 4, 16'h2000);
    rst = 1'b1;
    #1;
    chk_outputs_zero("t5_rst");
    for (int i = 4; i < 8; i++) begin
      bus.sdr_rd_data = 16'h2000 + 16'(i);
      tick();
      if (i == 5) rst = 1'b0;
    end
    bus.sdr_rd_valid = 1'b0;
    tick();
    chk("t5_no_writes", 32'(wr_q.size()),      32'd0);
    chk("t5_busy",      32'(bus.qspi_rd_busy), 32'd0);
    chk("t5_req",       32'(bus.sdr_rd_req),   32'd0);

    // Stray data beats while idle.
    for (int i = 0; i < 4; i++) begin
      bus.sdr_rd_valid = 1'b1;
      bus.sdr_rd_data  = 16'hDEA0 + 16'(i);
      tick();
      chk("t6_wen", 32'(bus.ram_wen), 32'd0);
    end
    bus.sdr_rd_valid = 1'b0;
    tick();
    chk("t6_no_writes", 32'(wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
